// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard and
//                forwarding controller: operand-select encodings, the shadow
//                scoreboard entry and the producer-match helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Operand mux select encodings
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Register index width held in a scoreboard entry; register indices of
    // up to this width are zero-extended into it by the controller.
    localparam int SB_RD_W = 8;

    // One in-flight instruction as seen by the controller
    typedef struct packed {
        logic               v;   // real instruction, not a bubble
        logic [SB_RD_W-1:0] rd;  // destination register
        logic               rw;  // writes the register file
        logic               mr;  // is a load
    } sb_entry_t;

    // A producer matches a source register when it will really write a
    // non-zero register with that index. Writes to r0 are discarded.
    function automatic logic sb_match(input sb_entry_t p, input logic [SB_RD_W-1:0] r);
        return p.v & p.rw & (p.rd != '0) & (p.rd == r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_forward_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_select
//  Description : Compares one ID-stage source register against the EX and MEM
//                scoreboard entries; yields the forwarding select (newest
//                producer wins) and the hit flags used for hazard detection.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_select
    import pipe_ctrl_pkg::*;
(
    input  logic               need,        // instruction really reads src
    input  logic [SB_RD_W-1:0] src,
    input  sb_entry_t          ex_ent,
    input  sb_entry_t          mem_ent,
    output logic [1:0]         sel,
    output logic               ex_hit,      // EX producer feeds src
    output logic               ex_ld_hit,   // ... and it is a load
    output logic               mem_ld_hit   // MEM load producer feeds src
);

    logic mem_hit;

    // Match evaluation and EX-over-MEM priority select
    always_comb begin
        ex_hit     = need & sb_match(ex_ent, src);
        mem_hit    = need & sb_match(mem_ent, src);
        ex_ld_hit  = ex_hit & ex_ent.mr;
        mem_ld_hit = mem_hit & mem_ent.mr;
        sel        = FWD_REG;
        if (ex_hit) begin
            sel = FWD_EXMEM;
        end else if (mem_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_ctrl
//  Description : Five-stage pipeline sequencing controller. Tracks in-flight
//                destinations, registers EX operand forwarding selects and
//                generates PC / IF-ID hold and ID/EX bubble insertion for
//                load-use and ID-branch operand hazards.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_forward_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,   // must not exceed SB_RD_W
    parameter int CNT_W        = 16,
    parameter int BRANCH_IN_ID = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,          // asynchronous, active low
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_branch,
    input  logic                  stall_ext,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_flush,
    output logic [CNT_W-1:0]      stall_cnt
);

    // The register file is write-first, so an instruction in WB never needs
    // forwarding or a stall; only EX and MEM are tracked.
    sb_entry_t        ex_q,  ex_d;
    sb_entry_t        mem_q, mem_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             need_a, need_b;
    logic [1:0]       sel_a, sel_b;
    logic             ex_hit_a, ex_hit_b;
    logic             ex_ld_a, ex_ld_b;
    logic             mem_ld_a, mem_ld_b;
    logic             br_en;
    logic             hz_load_use, hz_branch, hz;

    assign need_a = id_valid & id_uses_rs;
    assign need_b = id_valid & id_uses_rt;

    fwd_select u_fwd_a (
        .need       (need_a),
        .src        (SB_RD_W'(id_rs)),
        .ex_ent     (ex_q),
        .mem_ent    (mem_q),
        .sel        (sel_a),
        .ex_hit     (ex_hit_a),
        .ex_ld_hit  (ex_ld_a),
        .mem_ld_hit (mem_ld_a)
    );

    fwd_select u_fwd_b (
        .need       (need_b),
        .src        (SB_RD_W'(id_rt)),
        .ex_ent     (ex_q),
        .mem_ent    (mem_q),
        .sel        (sel_b),
        .ex_hit     (ex_hit_b),
        .ex_ld_hit  (ex_ld_b),
        .mem_ld_hit (mem_ld_b)
    );

    // Hazard detection: loads in EX block any consumer; a branch resolving in
    // ID additionally waits for any EX producer and for a load still in MEM.
    always_comb begin
        br_en       = (BRANCH_IN_ID != 0) & id_valid & id_branch;
        hz_load_use = ex_ld_a | ex_ld_b;
        hz_branch   = br_en & (ex_hit_a | ex_hit_b | mem_ld_a | mem_ld_b);
        hz          = hz_load_use | hz_branch;
    end

    // Next-state and stage-enable generation with freeze > stall > advance
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_flush  = 1'b0;
        ex_d        = ex_q;
        mem_d       = mem_q;
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;
        stall_cnt_d = stall_cnt_q;
        if (stall_ext) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (hz) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            ex_d       = '0;
            mem_d      = ex_q;
            fwd_a_d    = FWD_REG;
            fwd_b_d    = FWD_REG;
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_d    = '{v: id_valid, rd: SB_RD_W'(id_rd), rw: id_regwrite, mr: id_memread};
            mem_d   = ex_q;
            fwd_a_d = sel_a;
            fwd_b_d = sel_b;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            fwd_a_q     <= FWD_REG;
            fwd_b_q     <= FWD_REG;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_forward_ctrl
//  Description : Directed scoreboard bench for hazard_forward_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rs, id_uses_rt;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_regwrite, id_memread, id_branch, stall_ext;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        pc_write, ifid_write, idex_flush;
    logic [15:0] stall_cnt;

    typedef struct {
        int          cyc;
        logic [1:0]  a;
        logic [1:0]  b;
        logic        pc;
        logic        fl;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(16), .BRANCH_IN_ID(1)) dut (
        .Clk         (clk),
        .Rst         (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_branch   (id_branch),
        .stall_ext   (stall_ext),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .idex_flush  (idex_flush),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, got, want);
        end
    endtask

    // Drive one ID-stage instruction and queue the outputs expected this cycle
    task automatic issue(input logic v, input int rs, input int rt, input logic ur, input logic ut,
                         input int rd, input logic rw, input logic mr, input logic br, input logic ext,
                         input logic [1:0] ea, input logic [1:0] eb, input logic epc, input logic efl,
                         input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid    = v;
        id_rs       = 5'(rs);
        id_rt       = 5'(rt);
        id_uses_rs  = ur;
        id_uses_rt  = ut;
        id_rd       = 5'(rd);
        id_regwrite = rw;
        id_memread  = mr;
        id_branch   = br;
        stall_ext   = ext;
        e.cyc = cyc;
        e.a   = ea;
        e.b   = eb;
        e.pc  = epc;
        e.fl  = efl;
        e.cnt = 16'(ecnt);
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic nop(input logic [1:0] ea, input logic [1:0] eb, input int ecnt);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ea, eb, 1, 0, ecnt);
    endtask

    // Monitor: compare every queued expectation away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("fwd_a_sel",  e.cyc, 32'(fwd_a_sel),  32'(e.a));
                chk("fwd_b_sel",  e.cyc, 32'(fwd_b_sel),  32'(e.b));
                chk("pc_write",   e.cyc, 32'(pc_write),   32'(e.pc));
                chk("ifid_write", e.cyc, 32'(ifid_write), 32'(e.pc));
                chk("idex_flush", e.cyc, 32'(idex_flush), 32'(e.fl));
                chk("stall_cnt",  e.cyc, 32'(stall_cnt),  32'(e.cnt));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_rd = 0; id_regwrite = 0; id_memread = 0; id_branch = 0; stall_ext = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fwd_a", -1, 32'(fwd_a_sel), 0);
        chk("rst_pc",    -1, 32'(pc_write),  1);
        chk("rst_cnt",   -1, 32'(stall_cnt), 0);
        rst_n = 1'b1;

        // ALU producer -> immediate consumer: EX/MEM forward on A
        nop(2'b00, 2'b00, 0);
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);   // add r3
        issue(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);   // sub r5,r3,r4
        nop(2'b10, 2'b00, 0);
        // One-instruction gap: MEM/WB forward on A
        issue(1, 1, 2, 1, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);   // add r6
        nop(2'b00, 2'b00, 0);
        issue(1, 6, 6, 1, 0, 8, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);   // reads r6 on A only
        nop(2'b01, 2'b00, 0);
        // Load r2 then use in rt: one bubble, then MEM/WB forward on B
        issue(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0, 0);   // lw r2
        issue(1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);   // add r9,r1,r2 stalls
        issue(1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1);   // proceeds
        nop(2'b00, 2'b01, 1);
        nop(2'b00, 2'b00, 1);
        // Load r7 then beq r7,r0: two stall cycles
        issue(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0, 1);   // lw r7
        issue(1, 7, 0, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 1);
        issue(1, 7, 0, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 2);
        issue(1, 7, 0, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 3);
        nop(2'b00, 2'b00, 3);
        // ALU r7 then beq: one stall cycle
        issue(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 3);   // add r7
        issue(1, 7, 0, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 3);
        issue(1, 7, 0, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 4);
        nop(2'b01, 2'b00, 4);
        // Load to r0 then read r0: no stall, no forward
        issue(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0, 4);   // lw r0
        issue(1, 0, 0, 1, 1, 10, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 4);
        nop(2'b00, 2'b00, 4);
        // Same rd in EX and MEM: newest (EX/MEM) wins on both operands
        issue(1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 4);
        issue(1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 4);
        issue(1, 11, 11, 1, 1, 12, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 4);
        nop(2'b10, 2'b10, 4);
        // stall_ext during a load-use hazard freezes everything
        issue(1, 12, 0, 1, 0, 13, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0, 4);  // lw r13 (fwd r12 from MEM)
        issue(1, 13, 1, 1, 1, 14, 1, 0, 0, 1, 2'b01, 2'b00, 0, 0, 4);
        issue(1, 13, 1, 1, 1, 14, 1, 0, 0, 1, 2'b01, 2'b00, 0, 0, 4);
        issue(1, 13, 1, 1, 1, 14, 1, 0, 0, 0, 2'b01, 2'b00, 0, 1, 4);
        issue(1, 13, 1, 1, 1, 14, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 5);
        issue(1, 1, 0, 1, 0, 15, 1, 1, 0, 0, 2'b01, 2'b00, 1, 0, 5);   // lw r15
        issue(1, 15, 0, 1, 0, 16, 1, 0, 0, 0, 2'b00, 2'b00, 0, 1, 5);  // stalls

        // Reset mid-stall without a clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc",    cyc, 32'(pc_write),   1);
        chk("mid_rst_ifid",  cyc, 32'(ifid_write), 1);
        chk("mid_rst_flush", cyc, 32'(idex_flush), 0);
        chk("mid_rst_fwd_a", cyc, 32'(fwd_a_sel),  0);
        chk("mid_rst_cnt",   cyc, 32'(stall_cnt),  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Scoreboard emptied: the former load-use consumer no longer stalls
        issue(1, 15, 0, 1, 0, 16, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
        nop(2'b00, 2'b00, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
